// File: rtl/prm_pkg.sv
// rtl/prm_pkg.sv - shared types and constants for the obstacle scan block
//
// Purpose : scan-controller state encoding, obstacle code width and the
//           default number of edge checkers.
// Ports   : none (package)
package prm_pkg;

  // Obstacle voxel code width: bit 0 = checker input A ... bit 14 = input O.
  localparam int CODE_W       = 15;
  // Default number of edge checkers driven in parallel.
  localparam int NUM_EDGE_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } scan_state_e;

endpackage

// File: rtl/prm_oblgc_scan.sv
// rtl/prm_oblgc_scan.sv - obstacle-vs-edge collision scan controller
//
// Purpose : streams obstacle codes to an external bank of NUM_EDGE edge
//           checkers, ORs the returned per-edge hit masks over one frame and
//           hands the accumulated blocked mask back through a handshake.
// Ports   : clk, rst_n                 - clock, async active-low reset
//           start, abort               - frame start (IDLE only), frame drop
//           obs_valid/obs_ready/obs_code/obs_last - obstacle code stream in
//           chk_code                   - registered code to the checker bank
//           chk_mask                   - combinational hit mask from the bank
//           res_valid/res_ready/res_mask - frame result handshake
//           obs_cnt                    - accepted beats (PRM_SCAN_CNT_EN only)
//           busy                       - high outside IDLE
// Macro   : PRM_SCAN_CNT_EN adds the saturating obs_cnt beat counter.
module prm_oblgc_scan #(
  parameter int NUM_EDGE = prm_pkg::NUM_EDGE_DEF,
  parameter int CODE_W   = prm_pkg::CODE_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic                obs_valid,
  output logic                obs_ready,
  input  logic [CODE_W-1:0]   obs_code,
  input  logic                obs_last,
  output logic [CODE_W-1:0]   chk_code,
  input  logic [NUM_EDGE-1:0] chk_mask,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [NUM_EDGE-1:0] res_mask,
`ifdef PRM_SCAN_CNT_EN
  output logic [15:0]         obs_cnt,
`endif
  output logic                busy
);

  import prm_pkg::*;

  scan_state_e state;
  scan_state_e state_nxt;
  logic        stg_vld;   // chk_code holds a beat whose chk_mask is pending
  logic        accept;

  // Abort wins over a concurrent beat, so the handshake is withheld too.
  assign obs_ready = (state == ST_SCAN) && !abort;
  assign accept    = obs_ready && obs_valid;
  assign res_valid = (state == ST_DONE);
  assign busy      = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_SCAN;
      ST_SCAN:  if (accept && obs_last) state_nxt = ST_DRAIN;
      // One cycle lets the final beat's mask fold into res_mask.
      ST_DRAIN: state_nxt = ST_DONE;
      ST_DONE:  if (res_ready) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
    if (abort) state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_code <= '0;
      stg_vld  <= 1'b0;
      res_mask <= '0;
    end else if (abort) begin
      stg_vld <= 1'b0;
    end else if ((state == ST_IDLE) && start) begin
      res_mask <= '0;
      stg_vld  <= 1'b0;
    end else begin
      // chk_mask answers for the code registered on the previous accept.
      if (stg_vld) res_mask <= res_mask | chk_mask;
      stg_vld <= accept;
      if (accept) chk_code <= obs_code;
    end
  end

`ifdef PRM_SCAN_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      obs_cnt <= '0;
    end else if (!abort && (state == ST_IDLE) && start) begin
      obs_cnt <= '0;
    end else if (accept && (obs_cnt != 16'hFFFF)) begin
      obs_cnt <= obs_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_prm_oblgc_scan.sv
// tb/tb_prm_oblgc_scan.sv - self-checking bench for prm_oblgc_scan
module tb_prm_oblgc_scan;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, abort, obs_valid, obs_last, res_ready;
  logic        obs_ready, res_valid, busy;
  logic [14:0] obs_code, chk_code;
  logic [7:0]  chk_mask, res_mask;
`ifdef PRM_SCAN_CNT_EN
  logic [15:0] obs_cnt;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  // Checker-bank stub: fixed answers for the directed codes, else a sparse
  // one-hot hit chosen by code bits.
  function automatic logic [7:0] mask_of(input logic [14:0] c);
    case (c)
      15'h0001: return 8'h01;
      15'h1234: return 8'h00;
      15'h7FFF: return 8'h80;
      15'h4000: return 8'h00;
      default:  return c[3] ? 8'h00 : (8'h01 << c[6:4]);
    endcase
  endfunction

  assign chk_mask = mask_of(chk_code);

  prm_oblgc_scan dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .obs_valid (obs_valid),
    .obs_ready (obs_ready),
    .obs_code  (obs_code),
    .obs_last  (obs_last),
    .chk_code  (chk_code),
    .chk_mask  (chk_mask),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_mask  (res_mask),
`ifdef PRM_SCAN_CNT_EN
    .obs_cnt   (obs_cnt),
`endif
    .busy      (busy)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Offer one beat and return one step after the edge that accepted it.
  task automatic send_beat(input logic [14:0] code, input logic last, input int gap);
    int   guard;
    logic acc;
    guard = 0;
    repeat (gap) tick();
    obs_valid = 1'b1;
    obs_code  = code;
    obs_last  = last;
    do begin
      acc = obs_ready;
      tick();
      guard++;
    end while (!acc && guard < 50);
    if (!acc) check("beat_timeout", 32'd0, 32'd1);
    obs_valid = 1'b0;
    obs_last  = 1'b0;
  endtask

  task automatic finish_frame(input string tag, input logic [7:0] exp_mask,
                              input int exp_cnt, input int ready_dly);
    int w;
    w = 0;
    while (!res_valid && w < 20) begin
      tick();
      w++;
    end
    check({tag, "_latency"}, 32'(w), 32'd1);
    check({tag, "_mask"}, 32'(res_mask), 32'(exp_mask));
`ifdef PRM_SCAN_CNT_EN
    check({tag, "_cnt"}, 32'(obs_cnt), 32'(exp_cnt));
`else
    if (exp_cnt < 0) check({tag, "_cnt_arg"}, 32'(exp_cnt), 32'd0);
`endif
    repeat (ready_dly) tick();
    check({tag, "_valid_hold"}, 32'(res_valid), 32'd1);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check({tag, "_busy_after"}, 32'(busy), 32'd0);
    check({tag, "_valid_after"}, 32'(res_valid), 32'd0);
    check({tag, "_mask_held"}, 32'(res_mask), 32'(exp_mask));
  endtask

  typedef struct {
    int              n;
    logic [3:0][14:0] code;
    logic [7:0]      exp;
  } vec_t;

  vec_t tbl[4];

  task automatic set_vec(input int i, input int n, input logic [14:0] c0, input logic [14:0] c1,
                         input logic [14:0] c2, input logic [14:0] c3, input logic [7:0] e);
    tbl[i].n       = n;
    tbl[i].code[0] = c0;
    tbl[i].code[1] = c1;
    tbl[i].code[2] = c2;
    tbl[i].code[3] = c3;
    tbl[i].exp     = e;
  endtask

  initial begin
    logic [7:0]  acc_mask;
    logic [14:0] c;
    int          bad;

    set_vec(0, 3, 15'h0001, 15'h1234, 15'h7FFF, 15'h0000, 8'h81);
    set_vec(1, 1, 15'h4000, 15'h0000, 15'h0000, 15'h0000, 8'h00);
    set_vec(2, 4, 15'h0020, 15'h0050, 15'h0008, 15'h0001, 8'h25);
    set_vec(3, 2, 15'h7FFF, 15'h7FFF, 15'h0000, 15'h0000, 8'h80);

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; obs_valid = 1'b0;
    obs_last = 1'b0; res_ready = 1'b0; obs_code = '0;
    repeat (3) tick();
    check("rst_obs_ready", 32'(obs_ready), 32'd0);
    check("rst_chk_code", 32'(chk_code), 32'd0);
    check("rst_res_mask", 32'(res_mask), 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    tick();

    // Table-driven frames.
    for (int i = 0; i < 4; i++) begin
      do_start();
      check($sformatf("vec%0d_busy", i), 32'(busy), 32'd1);
      for (int b = 0; b < tbl[i].n; b++)
        send_beat(tbl[i].code[b], b == tbl[i].n - 1, 0);
      finish_frame($sformatf("vec%0d", i), tbl[i].exp, tbl[i].n, 0);
    end

    // Five-cycle gaps: chk_code stable, res_mask only the beats so far.
    do_start();
    acc_mask = 8'h00;
    for (int b = 0; b < 3; b++) begin
      c = (b == 0) ? 15'h0020 : (b == 1) ? 15'h0050 : 15'h0001;
      send_beat(c, b == 2, 0);
      acc_mask |= mask_of(c);
      if (b < 2) begin
        bad = 0;
        repeat (5) begin
          tick();
          if (chk_code !== c || res_mask !== acc_mask) bad++;
        end
        check($sformatf("gap%0d_stable", b), 32'(bad), 32'd0);
      end
    end
    finish_frame("gap", 8'h25, 3, 0);

    // Abort with the second beat offered.
    do_start();
    send_beat(15'h0001, 1'b0, 0);
    tick();
    check("abort_pre_mask", 32'(res_mask), 32'h01);
    obs_valid = 1'b1; obs_code = 15'h0050; obs_last = 1'b1; abort = 1'b1; res_ready = 1'b1;
    tick();
    obs_valid = 1'b0; obs_last = 1'b0; abort = 1'b0; res_ready = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_ready", 32'(obs_ready), 32'd0);
    bad = 0;
    repeat (6) begin
      tick();
      if (res_valid !== 1'b0 || busy !== 1'b0) bad++;
    end
    check("abort_no_result", 32'(bad), 32'd0);
    do_start();
    check("abort_next_clear", 32'(res_mask), 32'd0);
    send_beat(15'h4000, 1'b1, 0);
    finish_frame("abort_next", 8'h00, 1, 0);

    // Result held in DONE for 10 cycles while start is pulsed.
    do_start();
    send_beat(15'h0050, 1'b1, 0);
    tick();
    tick();
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      start = k[0];
      tick();
      if (res_valid !== 1'b1 || res_mask !== 8'h20 || busy !== 1'b1) bad++;
    end
    start = 1'b0;
    check("done_hold", 32'(bad), 32'd0);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("done_release_busy", 32'(busy), 32'd0);
    check("done_release_mask", 32'(res_mask), 32'h20);

    // Reset in the middle of a frame.
    do_start();
    send_beat(15'h0001, 1'b0, 0);
    send_beat(15'h0050, 1'b0, 0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_ready", 32'(obs_ready), 32'd0);
    check("midrst_code", 32'(chk_code), 32'd0);
    check("midrst_mask", 32'(res_mask), 32'd0);
    check("midrst_valid", 32'(res_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
`ifdef PRM_SCAN_CNT_EN
    check("midrst_cnt", 32'(obs_cnt), 32'd0);
`endif
    tick();
    rst_n = 1'b1;
    bad = 0;
    repeat (6) begin
      tick();
      if (res_valid !== 1'b0 || busy !== 1'b0) bad++;
    end
    check("midrst_no_result", 32'(bad), 32'd0);

    // Random frames against the OR-of-hits reference.
    for (int f = 0; f < 25; f++) begin
      int n;
      n = int'($urandom_range(1, 6));
      acc_mask = 8'h00;
      do_start();
      for (int b = 0; b < n; b++) begin
        c = 15'($urandom);
        acc_mask |= mask_of(c);
        send_beat(c, b == n - 1, int'($urandom_range(0, 3)));
      end
      finish_frame($sformatf("rnd%0d", f), acc_mask, n, int'($urandom_range(0, 4)));
    end

`ifdef PRM_SCAN_CNT_EN
    // Long frame saturates the beat counter.
    do_start();
    acc_mask = 8'h00;
    obs_valid = 1'b1;
    for (int i = 0; i < 70000; i++) begin
      c = 15'($urandom);
      acc_mask |= mask_of(c);
      obs_code = c;
      obs_last = (i == 69999);
      tick();
    end
    obs_valid = 1'b0;
    obs_last  = 1'b0;
    finish_frame("sat", acc_mask, 16'hFFFF, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
